fifo_tx_arbiter: RTL and testbench
==================================

FIFO_TX_ARBITER -- requirements
Module: fifo_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO read data and output stream data.
REQ-002 Parameter IFG_CYCLES, default 12, idle cycles inserted after every frame end.
REQ-003 Parameter MAX_FRAME_LEN, default 1518, maximum words forwarded per frame.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fifo0_data_out  input  DATA_WIDTH  FIFO 0 head word (first-word-fall-through, valid while fifo0_empty=0).
REQ-007 fifo0_last  input  1  frame-end marker stored alongside fifo0_data_out.
REQ-008 fifo0_empty  input  1  FIFO 0 empty flag.
REQ-009 fifo0_read_en  output  1  pops FIFO 0 head on the same posedge.
REQ-010 fifo1_data_out, fifo1_last, fifo1_empty, fifo1_read_en  same widths, directions and meanings for FIFO 1.
REQ-011 m_tdata  output  DATA_WIDTH  registered output stream data.
REQ-012 m_tvalid  output  1  output word valid.
REQ-013 m_tlast  output  1  output word ends frame.
REQ-014 m_tready  input  1  downstream accepts word when m_tvalid & m_tready.
REQ-015 grant  output  2  one-hot owner of the output; 2'b00 when no owner.
REQ-016 frame_done  output  1  one-cycle pulse when the output word with m_tlast=1 is accepted.
REQ-017 err_oversize  output  1  one-cycle pulse when a frame is truncated at MAX_FRAME_LEN.

Function
REQ-018 The FSM SHALL have states IDLE, XFER, FLUSH and GAP.
REQ-019 IDLE: if any FIFO is non-empty, the arbiter SHALL grant round-robin starting at the priority pointer, register grant and enter XFER the next cycle; no pop occurs in IDLE.
REQ-020 Priority pointer SHALL point to the FIFO not served last; it resets to FIFO 0.
REQ-021 XFER: read_en of the granted FIFO SHALL equal !empty & (!m_tvalid | m_tready) & !last_popped; the non-granted read_en SHALL be 0.
REQ-022 Each pop SHALL load m_tdata/m_tlast from the FIFO head and set m_tvalid on the next edge; an accepted word without a new pop SHALL clear m_tvalid.
REQ-023 A 16-bit word counter SHALL clear on grant and increment per pop.
REQ-024 Popping a word with last=1 SHALL stop popping; on its acceptance the FSM SHALL pulse frame_done, clear grant, toggle the priority pointer and enter GAP.
REQ-025 If the counter reaches MAX_FRAME_LEN on a pop with last=0, that word SHALL be output with m_tlast=1, err_oversize SHALL pulse, and FSM SHALL enter FLUSH.
REQ-026 FLUSH: the granted FIFO SHALL be popped whenever non-empty, data discarded (m_tvalid stays 0 after the truncated word is accepted), until a word with last=1 is popped, then GAP.
REQ-027 GAP: a counter SHALL hold for exactly IDLE_CYCLES... IFG_CYCLES cycles with grant=0 and no pops, then IDLE; IFG_CYCLES=0 SHALL go directly to IDLE.
REQ-028 m_tdata/m_tlast SHALL be held stable while m_tvalid=1 and m_tready=0.
REQ-029 FIFO empty mid-frame in XFER SHALL stall (m_tvalid drops after acceptance) without releasing grant.
REQ-030 Both FIFOs non-empty in IDLE SHALL be resolved solely by the priority pointer.

Reset
REQ-031 Reset SHALL force IDLE, grant=0, m_tvalid=0, m_tlast=0, m_tdata=0, both read_en=0, frame_done=0, err_oversize=0, counters=0, pointer=FIFO 0, effective the first edge it is high, including mid-frame.

Verification
REQ-032 FIFO 0 holds 4-word frame A1..A4, m_tready=1 -> grant=01 one cycle after non-empty, A1..A4 out on consecutive cycles, m_tlast on A4, frame_done once, then 12 idle cycles.
REQ-033 Both FIFOs hold 2-word frames at reset release -> FIFO 0 frame first, gap of 12, then FIFO 1 frame; next pair served FIFO 0 again.
REQ-034 m_tready toggled 1,0,0,1 during 4-word frame -> no word dropped or duplicated, m_tdata stable while stalled.
REQ-035 MAX_FRAME_LEN=4, FIFO 1 frame of 7 words -> 4 words output, 4th with m_tlast=1, err_oversize once, words 5-7 popped and discarded, then GAP.
REQ-036 reset asserted on 2nd word of a frame -> next cycle all outputs at reset values, grant=00, pointer FIFO 0.

Source files
------------

// File: rtl/fifo_tx_arbiter.sv
// Round-robin arbiter draining two frame FIFOs into one registered output stream,
// truncating frames longer than MAX_FRAME_LEN and inserting an inter-frame gap.
module fifo_tx_arbiter #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned IFG_CYCLES    = 12,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo0_data_out,
    input  logic                  fifo0_last,
    input  logic                  fifo0_empty,
    output logic                  fifo0_read_en,
    input  logic [DATA_WIDTH-1:0] fifo1_data_out,
    input  logic                  fifo1_last,
    input  logic                  fifo1_empty,
    output logic                  fifo1_read_en,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [1:0]            grant,
    output logic                  frame_done,
    output logic                  err_oversize
);

    typedef enum logic [1:0] {StIdle, StXfer, StFlush, StGap} state_e;

    localparam logic [15:0] MaxLen   = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] GapLast  = 16'(IFG_CYCLES - 1);
    localparam state_e      EndState = (IFG_CYCLES == 0) ? StIdle : StGap;

    state_e          r_state;
    logic            r_ptr;
    logic            r_last_popped;
    logic [15:0]     r_word_cnt;
    logic [15:0]     r_gap_cnt;

    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_last;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_trunc;
    logic                  w_flush_end;
    logic                  w_pick1;
    logic [15:0]           w_cnt_next;

    always_comb begin
        w_empty     = grant[1] ? fifo1_empty    : fifo0_empty;
        w_head_data = grant[1] ? fifo1_data_out : fifo0_data_out;
        w_head_last = grant[1] ? fifo1_last     : fifo0_last;
        w_accept    = m_tvalid & m_tready;
        // FLUSH discards, so it pops regardless of the output slot.
        w_pop = !r_last_popped && !w_empty &&
                (((r_state == StXfer) && (!m_tvalid || m_tready)) || (r_state == StFlush));
        w_cnt_next    = r_word_cnt + 16'd1;
        w_trunc       = w_pop && (r_state == StXfer) && !w_head_last && (w_cnt_next == MaxLen);
        w_flush_end   = (r_last_popped || (w_pop && w_head_last)) && (!m_tvalid || w_accept);
        w_pick1       = r_ptr ? !fifo1_empty : fifo0_empty;
        fifo0_read_en = w_pop & grant[0];
        fifo1_read_en = w_pop & grant[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_ptr         <= 1'b0;
            r_last_popped <= 1'b0;
            r_word_cnt    <= '0;
            r_gap_cnt     <= '0;
            grant         <= 2'b00;
            m_tdata       <= '0;
            m_tvalid      <= 1'b0;
            m_tlast       <= 1'b0;
            frame_done    <= 1'b0;
            err_oversize  <= 1'b0;
        end else begin
            frame_done   <= w_accept & m_tlast;
            err_oversize <= 1'b0;

            if (w_pop && (r_state == StXfer)) begin
                m_tdata  <= w_head_data;
                m_tlast  <= w_head_last | w_trunc;
                m_tvalid <= 1'b1;
            end else if (w_accept) begin
                m_tvalid <= 1'b0;
            end

            if (w_pop) begin
                r_word_cnt <= w_cnt_next;
                if (w_head_last) begin
                    r_last_popped <= 1'b1;
                end
            end

            case (r_state)
                StIdle: begin
                    if (!fifo0_empty || !fifo1_empty) begin
                        grant         <= w_pick1 ? 2'b10 : 2'b01;
                        r_word_cnt    <= '0;
                        r_last_popped <= 1'b0;
                        r_state       <= StXfer;
                    end
                end
                StXfer: begin
                    if (w_trunc) begin
                        err_oversize <= 1'b1;
                        r_state      <= StFlush;
                    end else if (w_accept && m_tlast) begin
                        grant     <= 2'b00;
                        r_ptr     <= ~grant[1];
                        r_gap_cnt <= '0;
                        r_state   <= EndState;
                    end
                end
                StFlush: begin
                    if (w_flush_end) begin
                        grant     <= 2'b00;
                        r_ptr     <= ~grant[1];
                        r_gap_cnt <= '0;
                        r_state   <= EndState;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GapLast) begin
                        r_state <= StIdle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Scoreboard bench for fifo_tx_arbiter: queue-modelled FIFOs feed the DUT, expected
// words are queued at stimulus time and a negedge monitor compares accepted words.
module tb_fifo_tx_arbiter;

    localparam int unsigned DW     = 8;
    localparam int unsigned IFG    = 12;
    localparam int unsigned MAXLEN = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] fifo0_data_out = '0;
    logic          fifo0_last = 1'b0;
    logic          fifo0_empty = 1'b1;
    logic          fifo0_read_en;
    logic [DW-1:0] fifo1_data_out = '0;
    logic          fifo1_last = 1'b0;
    logic          fifo1_empty = 1'b1;
    logic          fifo1_read_en;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [1:0]    grant;
    logic          frame_done;
    logic          err_oversize;

    fifo_tx_arbiter #(
        .DATA_WIDTH   (DW),
        .IFG_CYCLES   (IFG),
        .MAX_FRAME_LEN(MAXLEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo0_data_out(fifo0_data_out),
        .fifo0_last    (fifo0_last),
        .fifo0_empty   (fifo0_empty),
        .fifo0_read_en (fifo0_read_en),
        .fifo1_data_out(fifo1_data_out),
        .fifo1_last    (fifo1_last),
        .fifo1_empty   (fifo1_empty),
        .fifo1_read_en (fifo1_read_en),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .grant         (grant),
        .frame_done    (frame_done),
        .err_oversize  (err_oversize)
    );

    always #5 clk = ~clk;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [10:0] sb[$];   // {grant, last, data}

    int   n_checks = 0;
    int   n_errors = 0;
    int   fd_count = 0;
    int   eo_count = 0;
    int   cyc = 0;
    int   run_len = 0;
    int   max_run = 0;
    int   fd_cycle = 0;
    int   gap_checks = 0;
    bit   chk_gap = 1'b0;
    bit   fd_armed = 1'b0;
    logic [1:0] grant_prev = 2'b00;
    logic       stall_prev = 1'b0;
    logic [8:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO heads change just after the edge so the DUT always samples a settled head.
    always @(posedge clk) begin
        #2;
        fifo0_empty = (q0.size() == 0);
        {fifo0_last, fifo0_data_out} = (q0.size() != 0) ? q0[0] : 9'h0;
        fifo1_empty = (q1.size() == 0);
        {fifo1_last, fifo1_data_out} = (q1.size() != 0) ? q1[0] : 9'h0;
    end

    always @(negedge clk) begin
        logic [10:0] exp_w;
        if (reset) begin
            stall_prev = 1'b0;
            run_len    = 0;
            fd_armed   = 1'b0;
            grant_prev = 2'b00;
        end else begin
            if (fifo0_read_en) begin
                check("pop0_nonempty", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) void'(q0.pop_front());
            end
            if (fifo1_read_en) begin
                check("pop1_nonempty", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) void'(q1.pop_front());
            end
            if (frame_done) fd_count++;
            if (err_oversize) eo_count++;
            if (stall_prev) begin
                check("hold_valid", 32'(m_tvalid), 1);
                check("hold_word", 32'({m_tlast, m_tdata}), 32'(held));
            end
            stall_prev = m_tvalid && !m_tready;
            held = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h with nothing expected",
                             {grant, m_tlast, m_tdata});
                end else begin
                    exp_w = sb.pop_front();
                    check("out_word", 32'({grant, m_tlast, m_tdata}), 32'(exp_w));
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (frame_done) begin
                fd_armed = 1'b1;
                fd_cycle = cyc;
            end
            if (grant != 2'b00 && grant_prev == 2'b00) begin
                if (fd_armed && chk_gap) begin
                    gap_checks++;
                    check("ifg_len", 32'(cyc - fd_cycle), IFG + 1);
                end
                fd_armed = 1'b0;
            end
            grant_prev = grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit f, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            logic [8:0] w;
            w = {(i == n - 1), base + 8'(i)};
            if (f) q1.push_back(w);
            else q0.push_back(w);
            if (i < int'(MAXLEN))
                sb.push_back({(f ? 2'b10 : 2'b01), ((i == n - 1) || (i == int'(MAXLEN) - 1)),
                              base + 8'(i)});
        end
    endtask

    task automatic wait_fd(input int target);
        int k;
        k = 0;
        while (fd_count < target && k < 300) begin
            tick();
            k++;
        end
        check("frame_done_reached", 32'(fd_count >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_tvalid"}, 32'(m_tvalid), 0);
        check({tag, "_tlast"}, 32'(m_tlast), 0);
        check({tag, "_tdata"}, 32'(m_tdata), 0);
        check({tag, "_rd0"}, 32'(fifo0_read_en), 0);
        check({tag, "_rd1"}, 32'(fifo1_read_en), 0);
        check({tag, "_fdone"}, 32'(frame_done), 0);
        check({tag, "_ovr"}, 32'(err_oversize), 0);
    endtask

    initial begin
        int k;
        logic [3:0] pat;

        // Reset state
        reset = 1'b1;
        m_tready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst");

        // Single 4-word frame from FIFO 0
        reset = 1'b0;
        max_run = 0;
        push_frame(1'b0, 4, 8'hA1);
        #2;
        check("idle_no_pop", 32'(fifo0_read_en), 0);
        tick();
        check("grant_fifo0", 32'(grant), 32'h1);
        wait_fd(1);
        repeat (20) tick();
        check("fdone_once", 32'(fd_count), 1);
        check("back_to_back", 32'(max_run), 4);
        check("grant_released", 32'(grant), 0);
        check("sb_empty_a", 32'(sb.size()), 0);

        // Both FIFOs loaded at reset release, then a second pair
        chk_gap = 1'b1;
        reset = 1'b1;
        tick();
        push_frame(1'b0, 2, 8'hB1);
        push_frame(1'b1, 2, 8'hC1);
        reset = 1'b0;
        wait_fd(3);
        push_frame(1'b0, 2, 8'hD1);
        push_frame(1'b1, 2, 8'hE1);
        wait_fd(5);
        chk_gap = 1'b0;
        check("gap_measured", 32'(gap_checks), 3);
        check("sb_empty_rr", 32'(sb.size()), 0);

        // Oversize frame from FIFO 1 truncated at 4 words
        push_frame(1'b1, 7, 8'h11);
        wait_fd(6);
        k = 0;
        while ((q1.size() != 0 || grant != 2'b00) && k < 100) begin
            tick();
            k++;
        end
        check("flush_drained", 32'(q1.size()), 0);
        check("flush_grant_released", 32'(grant), 0);
        repeat (5) tick();
        check("oversize_once", 32'(eo_count), 1);
        check("flush_no_output", 32'(m_tvalid), 0);
        check("sb_empty_trunc", 32'(sb.size()), 0);

        // Backpressure pattern 1,0,0,1 mid-frame
        m_tready = 1'b0;
        push_frame(1'b0, 4, 8'h31);
        k = 0;
        while (!m_tvalid && k < 100) begin
            tick();
            k++;
        end
        check("bp_valid_seen", 32'(m_tvalid), 1);
        tick();
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            m_tready = pat[3-i];
            tick();
        end
        m_tready = 1'b1;
        wait_fd(7);
        check("sb_empty_bp", 32'(sb.size()), 0);

        // Reset on the second word of a frame; pointer must return to FIFO 0
        push_frame(1'b0, 4, 8'h41);
        k = 0;
        while (!(m_tvalid && m_tdata == 8'h42) && k < 100) begin
            tick();
            k++;
        end
        check("second_word_seen", 32'(m_tdata), 32'h42);
        reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        q0.delete();
        q1.delete();
        sb.delete();
        push_frame(1'b0, 2, 8'h51);
        push_frame(1'b1, 2, 8'h61);
        tick();
        reset = 1'b0;
        wait_fd(9);
        repeat (5) tick();
        check("sb_empty_end", 32'(sb.size()), 0);
        check("oversize_total", 32'(eo_count), 1);
        check("fdone_total", 32'(fd_count), 9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
